// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared sizing helpers for the adder tree and its feeder/consumers
package adder_tree_pkg;

   function automatic int tree_lat(input int num);
      return $clog2(num);
   endfunction

   function automatic int beats(input int num, input int lanes);
      return num / lanes;
   endfunction

endpackage

// File: rtl/valid_tag_delay.sv
// rtl/valid_tag_delay.sv - DEPTH-stage {valid,tag} shift register; DEPTH=0 is a wire
module valid_tag_delay #(
   parameter int DEPTH = 1,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         d_valid,
   input  logic [W-1:0] d_tag,
   output logic         q_valid,
   output logic [W-1:0] q_tag
);

   if (DEPTH == 0) begin : g_wire
      assign q_valid = d_valid;
      assign q_tag   = d_tag;
   end else begin : g_pipe
      logic [DEPTH-1:0] valid_sr;
      logic [W-1:0]     tag_sr [0:DEPTH-1];

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_sr <= '0;
            for (int i = 0; i < DEPTH; i++) tag_sr[i] <= '0;
         end else begin
            valid_sr[0] <= d_valid;
            tag_sr[0]   <= d_tag;
            for (int i = 1; i < DEPTH; i++) begin
               valid_sr[i] <= valid_sr[i-1];
               tag_sr[i]   <= tag_sr[i-1];
            end
         end
      end

      assign q_valid = valid_sr[DEPTH-1];
      assign q_tag   = tag_sr[DEPTH-1];
   end

endmodule

// File: rtl/adder_tree_frame_loader.sv
// rtl/adder_tree_frame_loader.sv - gathers LANES-wide beats into a NUM-entry frame for the adder tree
module adder_tree_frame_loader
   import adder_tree_pkg::*;
#(
   parameter int SIZE  = 10,
   parameter int NUM   = 1024,
   parameter int LANES = 4,
   parameter int TAG_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [LANES*SIZE-1:0]   s_data,
   input  logic                    s_last,
   input  logic                    flush,
   output logic [SIZE-1:0]         frame [0:NUM-1],
   output logic                    frame_valid,
   output logic [TAG_W-1:0]        frame_tag,
   output logic                    sum_valid,
   output logic [TAG_W-1:0]        sum_tag
);

   localparam int BEATS    = beats(NUM, LANES);
   localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TREE_LAT = tree_lat(NUM);

   if (NUM % LANES != 0) begin : g_bad_lanes
      $error("adder_tree_frame_loader: NUM must be a multiple of LANES");
   end

   logic              accept;
   logic              complete;
   logic [BEAT_W-1:0] beat;
   logic [TAG_W-1:0]  tag;
   logic [SIZE-1:0]   fill [0:NUM-1];

   assign s_ready  = !rst && !flush;
   assign accept   = s_valid && s_ready;
   assign complete = accept && ((beat == BEAT_W'(BEATS - 1)) || s_last);

   // fill is always zero beyond the current beat, so merging the live beat is enough to zero-pad
   always_ff @(posedge clk) begin
      if (rst) begin
         beat        <= '0;
         tag         <= '0;
         frame_valid <= 1'b0;
         frame_tag   <= '0;
         for (int i = 0; i < NUM; i++) begin
            fill[i]  <= '0;
            frame[i] <= '0;
         end
      end else begin
         frame_valid <= 1'b0;
         if (flush) begin
            beat <= '0;
            for (int i = 0; i < NUM; i++) fill[i] <= '0;
         end else if (accept) begin
            if (complete) begin
               for (int i = 0; i < NUM; i++) begin
                  frame[i] <= (BEAT_W'(i / LANES) == beat) ?
                              s_data[(i % LANES)*SIZE +: SIZE] : fill[i];
                  fill[i]  <= '0;
               end
               frame_valid <= 1'b1;
               frame_tag   <= tag;
               tag         <= tag + TAG_W'(1);
               beat        <= '0;
            end else begin
               for (int i = 0; i < NUM; i++) begin
                  if (BEAT_W'(i / LANES) == beat) fill[i] <= s_data[(i % LANES)*SIZE +: SIZE];
               end
               beat <= beat + BEAT_W'(1);
            end
         end
      end
   end

   valid_tag_delay #(
      .DEPTH (TREE_LAT),
      .W     (TAG_W)
   ) u_delay (
      .clk     (clk),
      .rst     (rst),
      .d_valid (frame_valid),
      .d_tag   (frame_tag),
      .q_valid (sum_valid),
      .q_tag   (sum_tag)
   );

endmodule

// File: tb/tb_adder_tree_frame_loader.sv
// tb/tb_adder_tree_frame_loader.sv - directed bench for the frame loader driving a 3-level adder tree
module tb_adder_tree_frame_loader;

   localparam int SIZE  = 10;
   localparam int NUM   = 8;
   localparam int LANES = 2;
   localparam int TAG_W = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  s_valid;
   logic                  s_ready;
   logic [LANES*SIZE-1:0] s_data;
   logic                  s_last;
   logic                  flush;
   logic [SIZE-1:0]       frame [0:NUM-1];
   logic                  frame_valid;
   logic [TAG_W-1:0]      frame_tag;
   logic                  sum_valid;
   logic [TAG_W-1:0]      sum_tag;

   adder_tree_frame_loader #(
      .SIZE (SIZE), .NUM (NUM), .LANES (LANES), .TAG_W (TAG_W)
   ) dut (
      .clk (clk), .rst (rst), .s_valid (s_valid), .s_ready (s_ready),
      .s_data (s_data), .s_last (s_last), .flush (flush), .frame (frame),
      .frame_valid (frame_valid), .frame_tag (frame_tag),
      .sum_valid (sum_valid), .sum_tag (sum_tag)
   );

   always #5 clk = ~clk;

   // Sink: pipelined 2:1 adder tree, no reset, latency 3
   logic [SIZE-1:0] t1 [0:3];
   logic [SIZE-1:0] t2 [0:1];
   logic [SIZE-1:0] dout;
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) t1[i] <= frame[2*i] + frame[2*i+1];
      for (int i = 0; i < 2; i++) t2[i] <= t1[2*i] + t1[2*i+1];
      dout <= t2[0] + t2[1];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [79:0] pack_frame();
      logic [79:0] p;
      for (int i = 0; i < NUM; i++) p[i*SIZE +: SIZE] = frame[i];
      return p;
   endfunction

   function automatic logic [79:0] mk(input int v [0:7]);
      logic [79:0] p;
      for (int i = 0; i < NUM; i++) p[i*SIZE +: SIZE] = v[i][SIZE-1:0];
      return p;
   endfunction

   int              fv_cyc_q [$];
   logic [TAG_W-1:0] fv_tag_q [$];
   logic [79:0]     fv_frame_q [$];
   int              sv_cyc_q [$];
   logic [TAG_W-1:0] sv_tag_q [$];
   logic [SIZE-1:0] sv_sum_q [$];
   logic            watch_ready = 1'b0;
   int              ready_drops = 0;

   always @(negedge clk) begin
      if (frame_valid) begin
         fv_cyc_q.push_back(cyc);
         fv_tag_q.push_back(frame_tag);
         fv_frame_q.push_back(pack_frame());
      end
      if (sum_valid) begin
         sv_cyc_q.push_back(cyc);
         sv_tag_q.push_back(sum_tag);
         sv_sum_q.push_back(dout);
      end
      if (watch_ready && !s_ready) ready_drops++;
   end

   task automatic clear_q();
      fv_cyc_q.delete(); fv_tag_q.delete(); fv_frame_q.delete();
      sv_cyc_q.delete(); sv_tag_q.delete(); sv_sum_q.delete();
   endtask

   task automatic send(input int a, input int b, input bit last);
      s_data  = {b[SIZE-1:0], a[SIZE-1:0]};
      s_valid = 1'b1;
      s_last  = last;
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic verify_one(input string tag, input logic [79:0] ef, input int etag,
                             input int esum, input int t_last);
      check({tag, ".fv_count"}, 80'(fv_cyc_q.size()), 80'd1);
      check({tag, ".sv_count"}, 80'(sv_cyc_q.size()), 80'd1);
      if (fv_cyc_q.size() == 1 && sv_cyc_q.size() == 1) begin
         check({tag, ".fv_cycle"}, 80'(fv_cyc_q[0]), 80'(t_last));
         check({tag, ".frame"}, fv_frame_q[0], ef);
         check({tag, ".frame_tag"}, 80'(fv_tag_q[0]), 80'(etag));
         check({tag, ".sum_lat"}, 80'(sv_cyc_q[0] - fv_cyc_q[0]), 80'd3);
         check({tag, ".sum"}, 80'(sv_sum_q[0]), 80'(esum));
         check({tag, ".sum_tag"}, 80'(sv_tag_q[0]), 80'(etag));
      end
      clear_q();
   endtask

   initial begin
      int t_last;
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; flush = 1'b0; s_data = '0;
      idle(3);
      check("rst.s_ready", 80'(s_ready), 80'd0);
      check("rst.frame_valid", 80'(frame_valid), 80'd0);
      check("rst.sum_valid", 80'(sum_valid), 80'd0);
      check("rst.frame_tag", 80'(frame_tag), 80'd0);
      check("rst.sum_tag", 80'(sum_tag), 80'd0);
      check("rst.frame", pack_frame(), 80'd0);
      rst = 1'b0;
      #1;
      check("idle.s_ready", 80'(s_ready), 80'd1);
      clear_q();

      // 1: full frame back-to-back
      send(1, 2, 0); send(3, 4, 0); send(5, 6, 0); send(7, 8, 0);
      t_last = cyc;
      idle(6);
      verify_one("t1", mk('{1, 2, 3, 4, 5, 6, 7, 8}), 0, 36, t_last);

      // 2: short frame via s_last
      send(1, 2, 0); send(3, 4, 1);
      t_last = cyc;
      idle(6);
      verify_one("t2", mk('{1, 2, 3, 4, 0, 0, 0, 0}), 1, 10, t_last);

      // 3: gaps between beats
      send(1, 2, 0); idle(2); send(3, 4, 0); idle(2);
      send(5, 6, 0); idle(2); send(7, 8, 0);
      t_last = cyc;
      idle(6);
      verify_one("t3", mk('{1, 2, 3, 4, 5, 6, 7, 8}), 2, 36, t_last);

      // 4: flush drops partial frame; a beat offered during flush is refused
      send(1, 2, 0); send(3, 4, 0);
      flush = 1'b1; s_valid = 1'b1; s_data = {10'd99, 10'd99};
      #1;
      check("t4.flush_ready", 80'(s_ready), 80'd0);
      @(posedge clk); #1;
      flush = 1'b0; s_valid = 1'b0;
      send(200, 200, 0); send(200, 200, 0); send(200, 200, 0); send(200, 200, 0);
      t_last = cyc;
      idle(6);
      verify_one("t4", mk('{200, 200, 200, 200, 200, 200, 200, 200}), 3, 576, t_last);

      // 5a: reset right after completion kills the in-flight sum
      send(1, 2, 0); send(3, 4, 0); send(5, 6, 0); send(7, 8, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(6);
      check("t5a.fv_count", 80'(fv_cyc_q.size()), 80'd1);
      check("t5a.sv_count", 80'(sv_cyc_q.size()), 80'd0);
      clear_q();

      // 5b: reset mid-frame
      send(9, 9, 0); send(9, 9, 0); send(9, 9, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5b.frame_valid", 80'(frame_valid), 80'd0);
      check("t5b.frame", pack_frame(), 80'd0);
      check("t5b.frame_tag", 80'(frame_tag), 80'd0);
      check("t5b.sum_valid", 80'(sum_valid), 80'd0);
      check("t5b.sum_tag", 80'(sum_tag), 80'd0);
      send(1, 2, 0); send(3, 4, 0); send(5, 6, 0); send(7, 8, 0);
      t_last = cyc;
      idle(6);
      verify_one("t5b", mk('{1, 2, 3, 4, 5, 6, 7, 8}), 0, 36, t_last);

      // 6: 19 frames at full rate, tag wraps
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      clear_q();
      watch_ready = 1'b1;
      for (int f = 0; f < 19; f++)
         for (int b = 0; b < 4; b++)
            send(8*f + 2*b + 1, 8*f + 2*b + 2, 0);
      watch_ready = 1'b0;
      idle(6);
      check("t6.ready_drops", 80'(ready_drops), 80'd0);
      check("t6.fv_count", 80'(fv_cyc_q.size()), 80'd19);
      check("t6.sv_count", 80'(sv_cyc_q.size()), 80'd19);
      if (fv_cyc_q.size() == 19 && sv_cyc_q.size() == 19) begin
         for (int i = 0; i < 19; i++) begin
            check($sformatf("t6.tag%0d", i), 80'(fv_tag_q[i]), 80'(i % 16));
            check($sformatf("t6.sum_tag%0d", i), 80'(sv_tag_q[i]), 80'(i % 16));
            check($sformatf("t6.sum%0d", i), 80'(sv_sum_q[i]), 80'((64*i + 36) % 1024));
            check($sformatf("t6.lat%0d", i), 80'(sv_cyc_q[i] - fv_cyc_q[i]), 80'd3);
            if (i > 0)
               check($sformatf("t6.period%0d", i), 80'(fv_cyc_q[i] - fv_cyc_q[i-1]), 80'd4);
         end
         check("t6.frame18", fv_frame_q[18],
               mk('{145, 146, 147, 148, 149, 150, 151, 152}));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
